// File: rtl/core_pipe_stage.sv
// core_pipe_stage: registered pipeline stage with a valid/ready handshake.
// Carries an opaque WIDTH-bit payload between two core stages, supports a
// synchronous flush, and runs either as a single-entry stage (SKID=0) or as
// a two-entry skid buffer with a registered s_ready (SKID=1). It also keeps
// a saturating count of backpressure cycles for the performance counters.

module core_pipe_stage #(
    parameter int                WIDTH    = 32,
    parameter int                SKID     = 0,
    parameter int                COUNT_W  = 16,
    parameter logic [WIDTH-1:0]  RST_DATA = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [1:0]         occupancy,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] stall_cnt
);

    // EMPTY: nothing held. ONE: main entry valid. FULL: main and skid valid
    // (FULL is only reachable when SKID=1).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_next;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_next;
    logic [1:0]         occ_q;
    logic [1:0]         occ_next;
    logic [COUNT_W-1:0] cnt_q;
    logic               up_xfer;
    logic               down_xfer;

    // The main entry drives the downstream side directly, so m_valid and
    // m_data are both straight out of flops.
    assign m_valid   = (state != EMPTY);
    assign m_data    = main_q;
    assign occupancy = occ_q;
    assign stall_cnt = cnt_q;

    assign up_xfer   = s_valid && s_ready;
    assign down_xfer = m_valid && m_ready;

    // The ready generation is the only structural difference between the
    // two modes: plain mode looks through to m_ready, skid mode registers it
    // so there is no combinational path from m_ready to s_ready.
    generate
        if (SKID != 0) begin : g_skid_ready
            logic s_ready_q;

            // Ready is high whenever the stage will not be FULL next cycle.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s_ready_q <= 1'b1;
                end else begin
                    s_ready_q <= (state_next != FULL);
                end
            end

            assign s_ready = s_ready_q;
        end else begin : g_plain_ready
            assign s_ready = !m_valid || m_ready;
        end
    endgenerate

    // Next-state and datapath selection; flush wins over every handshake and
    // discards any upstream offer, while a downstream transfer in the same
    // cycle simply completes because the consumer already sees m_valid.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;

        if (flush) begin
            state_next = EMPTY;
            main_next  = RST_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_xfer) begin
                        state_next = ONE;
                        main_next  = s_data;
                    end
                end
                ONE: begin
                    if (up_xfer && m_ready) begin
                        main_next = s_data;
                    end else if (up_xfer && (SKID != 0)) begin
                        state_next = FULL;
                        skid_next  = s_data;
                    end else if (down_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (m_ready) begin
                        state_next = ONE;
                        main_next  = skid_q;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Occupancy follows the next state so it is registered in step with it.
    always_comb begin
        occ_next = 2'd0;
        case (state_next)
            EMPTY:   occ_next = 2'd0;
            ONE:     occ_next = 2'd1;
            FULL:    occ_next = 2'd2;
            default: occ_next = 2'd0;
        endcase
    end

    // State, payload and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= RST_DATA;
            skid_q <= RST_DATA;
            occ_q  <= 2'd0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
            occ_q  <= occ_next;
        end
    end

    // Saturating backpressure counter; a clear takes precedence so the
    // clearing cycle itself is never counted, and flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (m_valid && !m_ready && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_pipe_stage.sv
// tb_core_pipe_stage: checks a plain (SKID=0) and a skid (SKID=1, COUNT_W=4)
// instance with a directed vector table, streaming runs, counter and reset
// corner sequences, and a random run against a small FIFO scoreboard.

module tb_core_pipe_stage;

    localparam logic [7:0] RST0 = 8'hC3;
    localparam logic [7:0] RST1 = 8'h5A;
    localparam logic       T    = 1'b1;
    localparam logic       F    = 1'b0;

    logic       clk;
    logic       rst_n;
    logic       flush     [2];
    logic       s_valid   [2];
    logic       s_ready   [2];
    logic [7:0] s_data    [2];
    logic       m_valid   [2];
    logic       m_ready   [2];
    logic [7:0] m_data    [2];
    logic [1:0] occupancy [2];
    logic       cnt_clr   [2];
    logic [15:0] stall0;
    logic [3:0]  stall1;

    int checks;
    int passes;

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       s_valid;
        logic [7:0] s_data;
        logic       m_ready;
        logic       cnt_clr;
        logic       exp_m_valid;
        logic       chk_data;
        logic [7:0] exp_m_data;
        logic [1:0] exp_occ;
        logic       exp_s_ready;
        logic [3:0] exp_stall;
    } vec_t;

    vec_t vecs[$];

    core_pipe_stage #(.WIDTH(8), .SKID(0), .COUNT_W(16), .RST_DATA(RST0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
        .occupancy(occupancy[0]), .cnt_clr(cnt_clr[0]), .stall_cnt(stall0)
    );

    core_pipe_stage #(.WIDTH(8), .SKID(1), .COUNT_W(4), .RST_DATA(RST1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
        .occupancy(occupancy[1]), .cnt_clr(cnt_clr[1]), .stall_cnt(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [31:0] stall_of(input int k);
        return (k == 0) ? 32'(stall0) : 32'(stall1);
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            flush[k]   = 1'b0;
            s_valid[k] = 1'b0;
            s_data[k]  = 8'h00;
            m_ready[k] = 1'b0;
            cnt_clr[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset m_valid0", 32'(m_valid[0]), 32'd0);
        check_output("reset m_data0", 32'(m_data[0]), 32'(RST0));
        check_output("reset occ0", 32'(occupancy[0]), 32'd0);
        check_output("reset stall0", stall_of(0), 32'd0);
        check_output("reset m_valid1", 32'(m_valid[1]), 32'd0);
        check_output("reset m_data1", 32'(m_data[1]), 32'(RST1));
        check_output("reset occ1", 32'(occupancy[1]), 32'd0);
        check_output("reset stall1", stall_of(1), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("release s_ready0", 32'(s_ready[0]), 32'd1);
        check_output("release s_ready1", 32'(s_ready[1]), 32'd1);
    endtask

    // Drives one table row into the skid instance and checks after the edge.
    task automatic apply_stimulus(input vec_t v, input int idx);
        rst_n      = v.rst_n;
        flush[1]   = v.flush;
        s_valid[1] = v.s_valid;
        s_data[1]  = v.s_data;
        m_ready[1] = v.m_ready;
        cnt_clr[1] = v.cnt_clr;
        @(posedge clk);
        #1;
        check_output($sformatf("vec%0d m_valid", idx), 32'(m_valid[1]), 32'(v.exp_m_valid));
        if (v.chk_data) begin
            check_output($sformatf("vec%0d m_data", idx), 32'(m_data[1]), 32'(v.exp_m_data));
        end
        check_output($sformatf("vec%0d occupancy", idx), 32'(occupancy[1]), 32'(v.exp_occ));
        check_output($sformatf("vec%0d s_ready", idx), 32'(s_ready[1]), 32'(v.exp_s_ready));
        check_output($sformatf("vec%0d stall", idx), stall_of(1), 32'(v.exp_stall));
    endtask

    task automatic run_stream(input int k);
        do_reset();
        m_ready[k] = 1'b1;
        s_valid[k] = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            s_data[k] = 8'(i);
            @(posedge clk);
            #1;
            check_output($sformatf("stream%0d valid %0d", k, i), 32'(m_valid[k]), 32'd1);
            check_output($sformatf("stream%0d data %0d", k, i), 32'(m_data[k]), 32'(i));
        end
        s_valid[k] = 1'b0;
        @(posedge clk);
        #1;
        check_output($sformatf("stream%0d drained", k), 32'(m_valid[k]), 32'd0);
        idle_inputs();
    endtask

    task automatic pulse(input int k, input logic sv, input logic [7:0] d, input logic mr);
        s_valid[k] = sv;
        s_data[k]  = d;
        m_ready[k] = mr;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] mq      [2][2];
    int         mcnt    [2];
    int         mstall  [2];
    logic       rst_view[2];
    logic       hold    [2];

    initial begin
        checks = 0;
        passes = 0;
        idle_inputs();
        rst_n = 1'b0;

        // rst_n flush s_valid s_data m_ready cnt_clr | m_valid chk data occ s_ready stall
        vecs.push_back('{T, F, T, 8'h0A, F, F, T, T, 8'h0A, 2'd1, T, 4'd0});
        vecs.push_back('{T, F, T, 8'h0B, F, F, T, T, 8'h0A, 2'd2, F, 4'd1});
        vecs.push_back('{T, F, T, 8'h0C, F, F, T, T, 8'h0A, 2'd2, F, 4'd2});
        vecs.push_back('{T, F, T, 8'h0C, T, F, T, T, 8'h0B, 2'd1, T, 4'd2});
        vecs.push_back('{T, F, T, 8'h0C, T, F, T, T, 8'h0C, 2'd1, T, 4'd2});
        vecs.push_back('{T, F, F, 8'h00, T, F, F, F, 8'h00, 2'd0, T, 4'd2});
        vecs.push_back('{T, F, T, 8'h11, F, F, T, T, 8'h11, 2'd1, T, 4'd2});
        vecs.push_back('{T, F, T, 8'h22, F, F, T, T, 8'h11, 2'd2, F, 4'd3});
        vecs.push_back('{T, T, T, 8'h0D, F, F, F, T, RST1,  2'd0, T, 4'd4});
        vecs.push_back('{T, F, F, 8'h00, F, F, F, T, RST1,  2'd0, T, 4'd4});
        vecs.push_back('{T, F, T, 8'h33, T, F, T, T, 8'h33, 2'd1, T, 4'd4});
        vecs.push_back('{T, T, T, 8'h44, T, F, F, T, RST1,  2'd0, T, 4'd4});
        vecs.push_back('{T, F, F, 8'h00, F, T, F, T, RST1,  2'd0, T, 4'd0});

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], i);
        end
        idle_inputs();

        // Counter saturation and clear on the COUNT_W=4 instance.
        pulse(1, 1'b1, 8'h77, 1'b0);
        s_valid[1] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_output("stall reaches max", stall_of(1), 32'd15);
        repeat (5) @(posedge clk);
        #1;
        check_output("stall saturated", stall_of(1), 32'd15);
        check_output("stall held data", 32'(m_data[1]), 32'h77);
        cnt_clr[1] = 1'b1;
        @(posedge clk);
        #1;
        check_output("stall cleared", stall_of(1), 32'd0);
        cnt_clr[1] = 1'b0;
        @(posedge clk);
        #1;
        check_output("stall counts again", stall_of(1), 32'd1);

        // Reset while FULL with both handshakes active discards everything.
        pulse(1, 1'b0, 8'h00, 1'b1);
        pulse(1, 1'b1, 8'h81, 1'b0);
        pulse(1, 1'b1, 8'h82, 1'b0);
        check_output("prefill occ", 32'(occupancy[1]), 32'd2);
        rst_n      = 1'b0;
        s_valid[1] = 1'b1;
        s_data[1]  = 8'h83;
        m_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check_output("midreset m_valid", 32'(m_valid[1]), 32'd0);
        check_output("midreset occ", 32'(occupancy[1]), 32'd0);
        check_output("midreset m_data", 32'(m_data[1]), 32'(RST1));
        check_output("midreset s_ready", 32'(s_ready[1]), 32'd1);
        rst_n = 1'b1;
        idle_inputs();

        // Plain mode: s_ready looks straight through to m_ready.
        do_reset();
        pulse(0, 1'b1, 8'h5C, 1'b0);
        s_valid[0] = 1'b0;
        #1;
        check_output("plain s_ready blocked", 32'(s_ready[0]), 32'd0);
        m_ready[0] = 1'b1;
        #1;
        check_output("plain s_ready through", 32'(s_ready[0]), 32'd1);
        check_output("plain m_data", 32'(m_data[0]), 32'h5C);
        idle_inputs();

        run_stream(0);
        run_stream(1);

        // Random traffic against a FIFO scoreboard on both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]     = 0;
            mstall[k]   = 0;
            rst_view[k] = 1'b1;
            hold[k]     = 1'b0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!hold[k]) begin
                    s_valid[k] = ($urandom_range(0, 9) < 6);
                    s_data[k]  = 8'($urandom);
                end
                m_ready[k] = ($urandom_range(0, 3) != 0);
                flush[k]   = ($urandom_range(0, 49) == 0);
                cnt_clr[k] = ($urandom_range(0, 99) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic exp_rdy;
                logic up;
                logic down;
                int   smax;
                smax    = (k == 0) ? 65535 : 15;
                exp_rdy = (k == 0) ? ((mcnt[k] == 0) || m_ready[k]) : (mcnt[k] != 2);
                check_output($sformatf("rnd%0d m_valid", k), 32'(m_valid[k]), 32'(mcnt[k] != 0));
                check_output($sformatf("rnd%0d occ", k), 32'(occupancy[k]), 32'(mcnt[k]));
                check_output($sformatf("rnd%0d s_ready", k), 32'(s_ready[k]), 32'(exp_rdy));
                check_output($sformatf("rnd%0d stall", k), stall_of(k), 32'(mstall[k]));
                if (mcnt[k] != 0) begin
                    check_output($sformatf("rnd%0d m_data", k), 32'(m_data[k]), 32'(mq[k][0]));
                end else if (rst_view[k]) begin
                    check_output($sformatf("rnd%0d rst data", k), 32'(m_data[k]),
                                 (k == 0) ? 32'(RST0) : 32'(RST1));
                end
                up   = s_valid[k] && exp_rdy;
                down = (mcnt[k] != 0) && m_ready[k];
                if (cnt_clr[k]) begin
                    mstall[k] = 0;
                end else if ((mcnt[k] != 0) && !m_ready[k] && (mstall[k] < smax)) begin
                    mstall[k]++;
                end
                if (down) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (flush[k]) begin
                    mcnt[k]     = 0;
                    rst_view[k] = 1'b1;
                end else if (up) begin
                    mq[k][mcnt[k]] = s_data[k];
                    mcnt[k]++;
                    rst_view[k] = 1'b0;
                end
                hold[k] = s_valid[k] && !up && !flush[k];
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
